qbert_position: RTL and testbench
=================================

QBERT_POSITION -- requirements
Module: qbert_position

Interface
REQ-001 SHALL have parameter N_ROW, default 7, meaning pyramid rows; cubes = N_ROW*(N_ROW+1)/2 = 28.
REQ-002 SHALL have ports, listed as name direction width meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- e_jump_req  in  3  requested direction: 001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT; 000 none.
- e_block  in  1  game not running (pause/tilt/freeze); requests ignored.
- e_abort  in  1  cancel any pending or in-flight jump (KO).
- e_respawn  in  1  one-cycle pulse; return to TOP.
- done_move_qb  in  1  move-complete level from the sprite stage.
- e_jump_qb  out  3  direction issued to the sprite stage.
- position_qb  out  28  one-hot current cube; 0 = off-pyramid.
- e_next_qb  out  28  one-hot target cube; 0 = off-pyramid.
- land_valid  out  1  one-cycle pulse on landing on a cube.
- land_cube  out  5  cube number 1..28, valid with land_valid.
- fell  out  1  one-cycle pulse on landing off-pyramid.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL hold position internally as row r (1..N_ROW) and index i (0..r-1); cube number n = r(r-1)/2 + i + 1; position_qb bit n-1 set.
REQ-004 SHALL compute next cell from (r, i) and direction:
- DOWN_RIGHT gives (r+1, i).
- DOWN_LEFT gives (r+1, i+1).
- UP_RIGHT gives (r-1, i-1).
- UP_LEFT gives (r-1, i).
REQ-005 SHALL treat a next row outside 1..N_ROW, or a next index outside 0..row-1, as off-pyramid: e_next_qb = 0.
REQ-006 SHALL implement FSM states IDLE, ISSUE, MOVE, FALLEN.
REQ-007 IDLE: on e_jump_req != 0 with e_block = 0, SHALL register e_jump_qb = dir and e_next_qb = next, and go to ISSUE on the next cycle.
REQ-008 ISSUE: on done_move_qb = 0 (sprite acknowledged), SHALL clear e_jump_qb to 000 and go to MOVE; e_jump_qb SHALL never be nonzero in MOVE.
REQ-009 MOVE: on done_move_qb = 1, SHALL set position_qb <= e_next_qb.
- If the target is on-pyramid: pulse land_valid with land_cube = target cube number, go to IDLE.
- If off-pyramid: pulse fell, go to FALLEN.
REQ-010 FALLEN: SHALL ignore requests; e_respawn SHALL set position = TOP (r=1, i=0), e_next_qb = TOP, and go to IDLE.
REQ-011 SHALL provide a one-entry request buffer: the first e_jump_req != 0 seen in ISSUE or MOVE is latched; later ones are dropped. After landing on-pyramid, the buffered request SHALL go directly from IDLE to ISSUE on the next cycle if e_block = 0; otherwise it is discarded.
REQ-012 SHALL clear the buffer on a fall, e_abort, or e_respawn.
REQ-013 In IDLE, e_next_qb SHALL equal position_qb, so the sprite stage sees no pending move.
REQ-014 e_abort SHALL take priority over all other inputs in every state:
- e_jump_qb = 0, buffer cleared, e_next_qb = position_qb, go to IDLE.
- Exception: in FALLEN the block SHALL stay in FALLEN.
REQ-015 e_respawn in IDLE, ISSUE or MOVE SHALL behave as in FALLEN (forced TOP, IDLE). e_abort and e_respawn in the same cycle SHALL give respawn.
REQ-016 land_valid and fell SHALL never assert together and SHALL be exactly one cycle wide.
REQ-017 All outputs SHALL be registered; request-to-e_jump_qb latency is 1 cycle.

Reset
REQ-018 On reset = 1 at a clock edge, the block SHALL go to state IDLE with these values, overriding any operation in progress:
- position_qb = e_next_qb = 28'h0000001.
- e_jump_qb = 0, buffer empty.
- land_valid = fell = busy = 0, land_cube = 0.

Structure
REQ-019 Shared package qbert_pkg SHALL hold:
- direction enum (NONE, DOWN_RIGHT, DOWN_LEFT, UP_RIGHT, UP_LEFT).
- edge-cube constants TOP, R02/R04/R07/R11/R16/R22, L03/L06/L10/L15/L21/L28.
- state enum.
REQ-020 SHALL contain one combinational sub-module cube_neighbour: (r, i, dir) -> (valid, next r, next i, one-hot, cube number).

Verification
REQ-021 Reset, then DOWN_LEFT; a sprite model drops done_move_qb 3 cycles later and raises it 20 cycles later -> e_jump_qb = 010 for exactly the ISSUE window, then position_qb = 28'h0000004, land_valid with land_cube = 3.
REQ-022 From TOP, UP_RIGHT -> e_next_qb = 0; after done_move_qb rises, fell pulses, state FALLEN, requests ignored; e_respawn -> position_qb = 28'h0000001.
REQ-023 Walk DOWN_RIGHT six times from TOP -> land_cube sequence 2, 4, 7, 11, 16, 22; a seventh DOWN_RIGHT -> fell.
REQ-024 A DOWN_LEFT request during MOVE, then a second request -> the first is issued 1 cycle after landing, the second is dropped; repeat with e_block = 1 at landing -> no issue, buffer empty.
REQ-025 e_abort during MOVE -> IDLE, e_jump_qb = 0, position unchanged, no land_valid.
REQ-026 Assert reset during MOVE -> all outputs equal the REQ-018 values on the next cycle.

Source files
------------

// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert position tracker: jump directions,
// tracker states and cube numbers of the pyramid's outer edges.
package qbert_pkg;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    DOWN_RIGHT = 3'd1,
    DOWN_LEFT  = 3'd2,
    UP_RIGHT   = 3'd3,
    UP_LEFT    = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MOVE,
    FALLEN
  } state_e;

  // Cube numbers along the right (index 0) and left (index r-1) edges.
  localparam int unsigned TOP = 1;
  localparam int unsigned R02 = 2;
  localparam int unsigned R04 = 4;
  localparam int unsigned R07 = 7;
  localparam int unsigned R11 = 11;
  localparam int unsigned R16 = 16;
  localparam int unsigned R22 = 22;
  localparam int unsigned L03 = 3;
  localparam int unsigned L06 = 6;
  localparam int unsigned L10 = 10;
  localparam int unsigned L15 = 15;
  localparam int unsigned L21 = 21;
  localparam int unsigned L28 = 28;

  function automatic logic is_dir(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/cube_neighbour.sv
// Combinational neighbour lookup: from (row, index, direction) produce the
// target cell, its one-hot cube vector and cube number, or invalid when off-pyramid.
module cube_neighbour
  import qbert_pkg::*;
#(
  parameter int unsigned N_ROW = 7,
  localparam int unsigned NC = N_ROW * (N_ROW + 1) / 2,
  localparam int unsigned CW = $clog2(NC + 1),
  localparam int unsigned RW = $clog2(N_ROW + 1)
) (
  input  logic [RW-1:0] row_i,
  input  logic [RW-1:0] idx_i,
  input  logic [2:0]    dir_i,
  output logic          valid_o,
  output logic [RW-1:0] row_o,
  output logic [RW-1:0] idx_o,
  output logic [NC-1:0] onehot_o,
  output logic [CW-1:0] cube_o
);

  localparam logic [NC-1:0] ONE = NC'(1);

  int nr;
  int ni;
  int n;

  always_comb begin
    nr = int'(row_i);
    ni = int'(idx_i);
    case (dir_i)
      DOWN_RIGHT: nr = nr + 1;
      DOWN_LEFT: begin
        nr = nr + 1;
        ni = ni + 1;
      end
      UP_RIGHT: begin
        nr = nr - 1;
        ni = ni - 1;
      end
      UP_LEFT: nr = nr - 1;
      default: ;
    endcase
    valid_o  = is_dir(dir_i) && (nr >= 1) && (nr <= int'(N_ROW)) && (ni >= 0) && (ni < nr);
    n        = nr * (nr - 1) / 2 + ni + 1;
    row_o    = '0;
    idx_o    = '0;
    onehot_o = '0;
    cube_o   = '0;
    if (valid_o) begin
      row_o    = nr[RW-1:0];
      idx_o    = ni[RW-1:0];
      onehot_o = ONE << (n - 1);
      cube_o   = n[CW-1:0];
    end
  end

endmodule

// File: rtl/qbert_position.sv
// Tracks Q*bert's cube on the pyramid: issues jumps to the sprite stage,
// waits for the move handshake, and reports landings or falls.
module qbert_position
  import qbert_pkg::*;
#(
  parameter int unsigned N_ROW = 7,
  localparam int unsigned NC = N_ROW * (N_ROW + 1) / 2,
  localparam int unsigned CW = $clog2(NC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    e_jump_req,
  input  logic          e_block,
  input  logic          e_abort,
  input  logic          e_respawn,
  input  logic          done_move_qb,
  output logic [2:0]    e_jump_qb,
  output logic [NC-1:0] position_qb,
  output logic [NC-1:0] e_next_qb,
  output logic          land_valid,
  output logic [CW-1:0] land_cube,
  output logic          fell,
  output logic          busy
);

  localparam int unsigned RW = $clog2(N_ROW + 1);
  localparam logic [NC-1:0] TOP_OH = NC'(1) << (TOP - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d, idx_q, idx_d;
  logic [RW-1:0] trow_q, trow_d, tidx_q, tidx_d;
  logic          tvalid_q, tvalid_d;
  logic [CW-1:0] tcube_q, tcube_d;
  logic [2:0]    jump_q, jump_d, buf_q, buf_d;
  logic          buf_v_q, buf_v_d;
  logic [NC-1:0] pos_q, pos_d, next_q, next_d;
  logic          lv_q, lv_d, fell_q, fell_d, busy_q, busy_d;
  logic [CW-1:0] lcube_q, lcube_d;

  logic [2:0]    nb_dir;
  logic          nb_valid;
  logic [RW-1:0] nb_row, nb_idx;
  logic [NC-1:0] nb_onehot;
  logic [CW-1:0] nb_cube;
  logic          req_ok;

  assign req_ok = is_dir(e_jump_req) && !e_block;
  assign nb_dir = (state_q == IDLE && buf_v_q) ? buf_q : e_jump_req;

  cube_neighbour #(.N_ROW(N_ROW)) u_nb (
    .row_i    (row_q),
    .idx_i    (idx_q),
    .dir_i    (nb_dir),
    .valid_o  (nb_valid),
    .row_o    (nb_row),
    .idx_o    (nb_idx),
    .onehot_o (nb_onehot),
    .cube_o   (nb_cube)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    trow_d   = trow_q;
    tidx_d   = tidx_q;
    tvalid_d = tvalid_q;
    tcube_d  = tcube_q;
    jump_d   = jump_q;
    buf_d    = buf_q;
    buf_v_d  = buf_v_q;
    pos_d    = pos_q;
    next_d   = next_q;
    lv_d     = 1'b0;
    fell_d   = 1'b0;
    lcube_d  = lcube_q;
    if (e_respawn) begin
      state_d = IDLE;
      pos_d   = TOP_OH;
      next_d  = TOP_OH;
      row_d   = RW'(1);
      idx_d   = '0;
      jump_d  = NONE;
      buf_v_d = 1'b0;
    end else if (e_abort) begin
      jump_d  = NONE;
      buf_v_d = 1'b0;
      next_d  = pos_q;
      if (state_q != FALLEN) state_d = IDLE;
    end else begin
      if ((state_q == ISSUE || state_q == MOVE) && req_ok && !buf_v_q) begin
        buf_v_d = 1'b1;
        buf_d   = e_jump_req;
      end
      unique case (state_q)
        IDLE: begin
          // A buffered request left over from the last move takes precedence over a fresh one.
          buf_v_d = 1'b0;
          if ((buf_v_q && !e_block) || (!buf_v_q && req_ok)) begin
            jump_d   = nb_dir;
            next_d   = nb_onehot;
            trow_d   = nb_row;
            tidx_d   = nb_idx;
            tvalid_d = nb_valid;
            tcube_d  = nb_cube;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          if (!done_move_qb) begin
            jump_d  = NONE;
            state_d = MOVE;
          end
        end
        MOVE: begin
          if (done_move_qb) begin
            pos_d = next_q;
            if (tvalid_q) begin
              row_d   = trow_q;
              idx_d   = tidx_q;
              lv_d    = 1'b1;
              lcube_d = tcube_q;
              state_d = IDLE;
            end else begin
              fell_d  = 1'b1;
              buf_v_d = 1'b0;
              state_d = FALLEN;
            end
          end
        end
        FALLEN: ;
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= RW'(1);
      idx_q    <= '0;
      trow_q   <= '0;
      tidx_q   <= '0;
      tvalid_q <= 1'b0;
      tcube_q  <= '0;
      jump_q   <= NONE;
      buf_q    <= NONE;
      buf_v_q  <= 1'b0;
      pos_q    <= TOP_OH;
      next_q   <= TOP_OH;
      lv_q     <= 1'b0;
      fell_q   <= 1'b0;
      busy_q   <= 1'b0;
      lcube_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      trow_q   <= trow_d;
      tidx_q   <= tidx_d;
      tvalid_q <= tvalid_d;
      tcube_q  <= tcube_d;
      jump_q   <= jump_d;
      buf_q    <= buf_d;
      buf_v_q  <= buf_v_d;
      pos_q    <= pos_d;
      next_q   <= next_d;
      lv_q     <= lv_d;
      fell_q   <= fell_d;
      busy_q   <= busy_d;
      lcube_q  <= lcube_d;
    end
  end

  assign e_jump_qb   = jump_q;
  assign position_qb = pos_q;
  assign e_next_qb   = next_q;
  assign land_valid  = lv_q;
  assign land_cube   = lcube_q;
  assign fell        = fell_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_qbert_position.sv
// Scoreboard bench for qbert_position: a pyramid model predicts each landing or
// fall; a monitor checks every land_valid/fell pulse against the queued prediction.
module tb_qbert_position;

  logic        clk;
  logic        reset;
  logic [2:0]  e_jump_req;
  logic        e_block;
  logic        e_abort;
  logic        e_respawn;
  logic        done_move_qb;
  logic [2:0]  e_jump_qb;
  logic [27:0] position_qb;
  logic [27:0] e_next_qb;
  logic        land_valid;
  logic [4:0]  land_cube;
  logic        fell;
  logic        busy;

  qbert_position #(.N_ROW(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .e_jump_req   (e_jump_req),
    .e_block      (e_block),
    .e_abort      (e_abort),
    .e_respawn    (e_respawn),
    .done_move_qb (done_move_qb),
    .e_jump_qb    (e_jump_qb),
    .position_qb  (position_qb),
    .e_next_qb    (e_next_qb),
    .land_valid   (land_valid),
    .land_cube    (land_cube),
    .fell         (fell),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          fell;
    int          cube;
    logic [27:0] pos;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mr, mi;

  function automatic int cube_of(input int r, input int i);
    return r * (r - 1) / 2 + i + 1;
  endfunction

  function automatic logic [27:0] oh(input int c);
    logic [27:0] one;
    one = 28'd1;
    return (c == 0) ? 28'd0 : (one << (c - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    bit   width_pending;
    width_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (width_pending) begin
        chk("pulse_width", 32'({land_valid, fell}), 32'd0);
        width_pending = 1'b0;
      end
      if (land_valid === 1'b1 || fell === 1'b1) begin
        width_pending = 1'b1;
        chk("lv_fell_exclusive", 32'(land_valid & fell), 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: land_valid=%0b fell=%0b cube=%0d with empty scoreboard",
                   land_valid, fell, land_cube);
        end else begin
          e = q.pop_front();
          chk("event_kind_fell", 32'(fell), 32'(e.fell));
          if (!e.fell) chk("land_cube", 32'(land_cube), 32'(e.cube));
          chk("event_position", 32'(position_qb), 32'(e.pos));
        end
      end
    end
  endtask

  // Sprite side of one jump: ack after lo cycles, finish after hi more cycles,
  // optionally injecting requests during the move and blocking at landing.
  task automatic run_move(input logic [2:0] dir, input int lo, input int hi,
                          input logic [2:0] inj1, input logic [2:0] inj2, input bit blk);
    exp_t e;
    int   nr, ni, cnt, k;
    bit   ok;
    k = 0;
    while (e_jump_qb == 3'd0 && k < 4) begin
      step();
      k++;
    end
    chk("issue_dir", 32'(e_jump_qb), 32'(dir));
    chk("busy_in_issue", 32'(busy), 32'd1);
    nr = mr;
    ni = mi;
    case (dir)
      3'd1: nr = mr + 1;
      3'd2: begin nr = mr + 1; ni = mi + 1; end
      3'd3: begin nr = mr - 1; ni = mi - 1; end
      default: nr = mr - 1;
    endcase
    ok     = (nr >= 1) && (nr <= 7) && (ni >= 0) && (ni < nr);
    e.fell = !ok;
    e.cube = ok ? cube_of(nr, ni) : 0;
    e.pos  = oh(e.cube);
    q.push_back(e);
    chk("next_target", 32'(e_next_qb), 32'(e.pos));
    cnt = 1;
    repeat (lo) begin
      step();
      if (e_jump_qb != 3'd0) cnt++;
    end
    done_move_qb = 1'b0;
    for (int j = 0; j < hi; j++) begin
      e_jump_req = (j == 1) ? inj1 : (j == 3) ? inj2 : 3'd0;
      step();
      if (e_jump_qb != 3'd0) cnt++;
    end
    e_jump_req = 3'd0;
    chk("jump_window", 32'(cnt), 32'(lo + 1));
    done_move_qb = 1'b1;
    e_block = blk;
    step();
    step();
    chk("post_position", 32'(position_qb), 32'(e.pos));
    chk("follow_issue", 32'(e_jump_qb), 32'((ok && inj1 != 3'd0 && !blk) ? inj1 : 3'd0));
    e_block = 1'b0;
    if (ok) begin
      mr = nr;
      mi = ni;
    end
  endtask

  task automatic jump(input logic [2:0] dir, input int lo, input int hi,
                      input logic [2:0] inj1, input logic [2:0] inj2, input bit blk);
    e_jump_req = dir;
    step();
    e_jump_req = 3'd0;
    chk("req_latency", 32'(e_jump_qb), 32'(dir));
    run_move(dir, lo, hi, inj1, inj2, blk);
  endtask

  task automatic respawn();
    e_respawn = 1'b1;
    step();
    e_respawn = 1'b0;
    chk("respawn_pos", 32'(position_qb), 32'h1);
    chk("respawn_next", 32'(e_next_qb), 32'h1);
    chk("respawn_busy", 32'(busy), 32'd0);
    mr = 1;
    mi = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pos"}, 32'(position_qb), 32'h1);
    chk({tag, "_next"}, 32'(e_next_qb), 32'h1);
    chk({tag, "_jump"}, 32'(e_jump_qb), 32'd0);
    chk({tag, "_lv"}, 32'(land_valid), 32'd0);
    chk({tag, "_fell"}, 32'(fell), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cube"}, 32'(land_cube), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    e_jump_req = 3'd0;
    e_block = 1'b0;
    e_abort = 1'b0;
    e_respawn = 1'b0;
    done_move_qb = 1'b1;
    mr = 1;
    mi = 0;
    step();
    step();
    reset = 1'b0;
    fork
      monitor();
    join_none
    check_reset_values("reset");

    // DOWN_LEFT from TOP with a 3/20 cycle sprite handshake lands on cube 3.
    jump(3'd2, 3, 20, 3'd0, 3'd0, 1'b0);
    chk("dl_position", 32'(position_qb), 32'h4);
    respawn();

    // UP_RIGHT from TOP falls off; requests and abort are ignored while fallen.
    jump(3'd3, 2, 4, 3'd0, 3'd0, 1'b0);
    e_jump_req = 3'd1;
    step();
    e_jump_req = 3'd0;
    step();
    chk("fallen_no_issue", 32'(e_jump_qb), 32'd0);
    chk("fallen_busy", 32'(busy), 32'd1);
    chk("fallen_pos", 32'(position_qb), 32'd0);
    e_abort = 1'b1;
    step();
    e_abort = 1'b0;
    chk("fallen_abort_stays", 32'(busy), 32'd1);
    respawn();

    // Right-edge walk: 2,4,7,11,16,22, then off the bottom.
    repeat (7) jump(3'd1, 1, 3, 3'd0, 3'd0, 1'b0);
    respawn();

    // One-entry buffer: first request during the move is issued after landing, the second dropped.
    jump(3'd1, 1, 6, 3'd2, 3'd4, 1'b0);
    run_move(3'd2, 2, 3, 3'd0, 3'd0, 1'b0);
    step();
    step();
    chk("dropped_second_jump", 32'(e_jump_qb), 32'd0);
    chk("dropped_second_busy", 32'(busy), 32'd0);
    // Blocked at landing: buffered request is discarded, later fresh request wins.
    jump(3'd1, 1, 6, 3'd2, 3'd0, 1'b1);
    step();
    step();
    chk("discarded_jump", 32'(e_jump_qb), 32'd0);
    chk("discarded_busy", 32'(busy), 32'd0);
    jump(3'd4, 0, 2, 3'd0, 3'd0, 1'b0);

    // Abort during MOVE: back to IDLE, position kept, no landing reported.
    e_jump_req = 3'd2;
    step();
    e_jump_req = 3'd0;
    step();
    done_move_qb = 1'b0;
    step();
    step();
    chk("move_jump_zero", 32'(e_jump_qb), 32'd0);
    chk("move_busy", 32'(busy), 32'd1);
    e_abort = 1'b1;
    step();
    e_abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_jump", 32'(e_jump_qb), 32'd0);
    chk("abort_next", 32'(e_next_qb), 32'(oh(cube_of(mr, mi))));
    chk("abort_pos", 32'(position_qb), 32'(oh(cube_of(mr, mi))));
    done_move_qb = 1'b1;
    step();
    chk("abort_no_land", 32'(land_valid), 32'd0);
    step();

    // Reset during MOVE overrides everything.
    e_jump_req = 3'd1;
    step();
    e_jump_req = 3'd0;
    done_move_qb = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("midmove_reset");
    mr = 1;
    mi = 0;
    done_move_qb = 1'b1;
    step();
    step();

    // Random walk against the pyramid model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] d;
      d = 3'($urandom_range(1, 4));
      jump(d, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), 3'd0, 3'd0, 1'b0);
      if (position_qb == 28'd0) respawn();
    end

    step();
    step();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
